reg_file_param: RTL and testbench

- Parametrised successor to the processor's fixed 8x8 register file.
- Contents: DEPTH = 2**ADDR_WIDTH registers of DATA_WIDTH bits.
- Ports: two asynchronous read ports and one synchronous write port with write acknowledge.
- Reset is a sequential clear sweep (one register per cycle) with a BUSY flag, so the CPU control unit stalls until the file is clean.
- Sits between the instruction decoder/ALU and the writeback path of the single-cycle datapath.

---
 rtl/reg_file_param.sv | 123 ++++++++++++
 tb/tb_reg_file_param.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// reg_file_param: DEPTH = 2**ADDR_WIDTH registers of DATA_WIDTH bits with two
// combinational read ports and one synchronous write port with acknowledge.
// RESET starts a clear sweep (one register per cycle); BUSY is high during
// the sweep, writes are dropped and both read ports return zero.
// Optional build macro REG_FILE_BYPASS_EN: forwards IN to a read port whose
// address matches INADDRESS while WRITE is high and the file is not busy.
module reg_file_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] INADDRESS,
  input  logic [DATA_WIDTH-1:0] IN,
  input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
  input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
  output logic [DATA_WIDTH-1:0] OUT1,
  output logic [DATA_WIDTH-1:0] OUT2,
  output logic                  BUSY,
  output logic                  WACK
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cidx;
  logic [ADDR_WIDTH-1:0] w_cidx_nxt;
  logic                  r_wack;
  logic                  w_wack_nxt;
  logic                  w_clr_en;
  logic [ADDR_WIDTH-1:0] w_clr_idx;
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Control state: FSM state, clear index and write acknowledge.
  always_ff @(posedge CLK) begin
    r_state <= w_state_nxt;
    r_cidx  <= w_cidx_nxt;
    r_wack  <= w_wack_nxt;
  end

  // Next-state logic; RESET wins over everything, including a pending write.
  always_comb begin
    w_state_nxt = r_state;
    w_cidx_nxt  = r_cidx;
    w_wack_nxt  = 1'b0;
    w_clr_en    = 1'b0;
    w_clr_idx   = r_cidx;
    w_wr_en     = 1'b0;
    if (RESET) begin
      // Restart the sweep; register 0 is cleared on this very edge and
      // again on the first sweep edge, which keeps BUSY at DEPTH cycles.
      w_state_nxt = S_CLEAR;
      w_cidx_nxt  = '0;
      w_clr_en    = 1'b1;
      w_clr_idx   = '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          w_clr_en   = 1'b1;
          w_cidx_nxt = r_cidx + 1'b1;
          if (r_cidx == LAST_IDX) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          if (WRITE) begin
            w_wr_en    = 1'b1;
            w_wack_nxt = 1'b1;
          end
        end
      endcase
    end
  end

  // Register storage: clear sweep has priority; writes only land when idle.
  always_ff @(posedge CLK) begin
    if (w_clr_en) begin
      r_mem[w_clr_idx] <= '0;
    end else if (w_wr_en) begin
      r_mem[INADDRESS] <= IN;
    end
  end

  assign BUSY = (r_state == S_CLEAR);
  assign WACK = r_wack;

`ifdef REG_FILE_BYPASS_EN
  logic w_byp1;
  logic w_byp2;
  assign w_byp1 = WRITE && !BUSY && (OUT1ADDRESS == INADDRESS);
  assign w_byp2 = WRITE && !BUSY && (OUT2ADDRESS == INADDRESS);

  // Read ports with write forwarding; masked to zero during the sweep.
  always_comb begin
    OUT1 = '0;
    OUT2 = '0;
    if (!BUSY) begin
      OUT1 = w_byp1 ? IN : r_mem[OUT1ADDRESS];
      OUT2 = w_byp2 ? IN : r_mem[OUT2ADDRESS];
    end
  end
`else
  // Read ports show stored contents; masked to zero during the sweep.
  always_comb begin
    OUT1 = '0;
    OUT2 = '0;
    if (!BUSY) begin
      OUT1 = r_mem[OUT1ADDRESS];
      OUT2 = r_mem[OUT2ADDRESS];
    end
  end
`endif

endmodule

// File: tb/tb_reg_file_param.sv
// Testbench for reg_file_param (default parameters: 8 x 8-bit).
// Directed vector table, hand-written reset/bypass sequences and a
// randomized run, all checked against a behavioural model of the file.
module tb_reg_file_param;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          CLK;
  logic          RESET;
  logic          WRITE;
  logic [AW-1:0] INADDRESS;
  logic [DW-1:0] IN;
  logic [AW-1:0] OUT1ADDRESS;
  logic [AW-1:0] OUT2ADDRESS;
  logic [DW-1:0] OUT1;
  logic [DW-1:0] OUT2;
  logic          BUSY;
  logic          WACK;

  reg_file_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .OUT1(OUT1), .OUT2(OUT2), .BUSY(BUSY), .WACK(WACK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: contents, cycles of BUSY left, last-edge acknowledge.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_busy  = 0;
  logic          m_wack  = 1'b0;
  logic          m_valid = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
    if (m_busy > 0) return '0;
`ifdef REG_FILE_BYPASS_EN
    if (WRITE && a == INADDRESS) return IN;
`endif
    return m_mem[a];
  endfunction

  // Apply one clock edge to the model using the inputs held across it.
  task automatic model_edge(input logic rst, input logic wr, input logic [AW-1:0] ia,
                            input logic [DW-1:0] din);
    if (rst) begin
      m_busy  = DEPTH;
      m_wack  = 1'b0;
      m_valid = 1'b1;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else begin
      m_wack = (m_busy == 0) && wr;
      if (m_busy == 0 && wr) m_mem[ia] = din;
      else if (m_busy > 0) m_busy--;
    end
  endtask

  // One cycle: drive at negedge, check reads before the edge, check all after.
  task automatic step(input logic rst, input logic wr, input logic [AW-1:0] ia,
                      input logic [DW-1:0] din, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    @(negedge CLK);
    RESET = rst; WRITE = wr; INADDRESS = ia; IN = din;
    OUT1ADDRESS = a1; OUT2ADDRESS = a2;
    #1;
    if (m_valid) begin
      chk("pre_out1", OUT1, m_rd(a1));
      chk("pre_out2", OUT2, m_rd(a2));
    end
    @(posedge CLK);
    model_edge(rst, wr, ia, din);
    #1;
    chk("busy", BUSY, (m_busy > 0) ? 8'd1 : 8'd0);
    chk("wack", WACK, m_wack ? 8'd1 : 8'd0);
    chk("out1", OUT1, m_rd(a1));
    chk("out2", OUT2, m_rd(a2));
  endtask

  typedef struct {
    logic          rst;
    logic          wr;
    logic [AW-1:0] ia;
    logic [DW-1:0] din;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic          e_busy;
    logic          e_wack;
    logic [DW-1:0] e_o1;
    logic [DW-1:0] e_o2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic wr, logic [AW-1:0] ia, logic [DW-1:0] din,
                              logic [AW-1:0] a1, logic [AW-1:0] a2, logic eb, logic ew,
                              logic [DW-1:0] e1, logic [DW-1:0] e2);
    vec_t v;
    v.rst = rst; v.wr = wr; v.ia = ia; v.din = din; v.a1 = a1; v.a2 = a2;
    v.e_busy = eb; v.e_wack = ew; v.e_o1 = e1; v.e_o2 = e2;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bcnt;
    RESET = 1'b0; WRITE = 1'b0; INADDRESS = '0; IN = '0;
    OUT1ADDRESS = '0; OUT2ADDRESS = '0;

    // Post-edge expectations for reset sweep, simple write, back-to-back
    // writes and a write dropped during the sweep.
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 8'h00));
    for (int i = 1; i < 8; i++) vecs.push_back(mk(0, 0, 0, 8'h00, 3'(i), 3'(7 - i), 1, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 7, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 1, 1, 8'h0F, 0, 1, 0, 1, 8'h00, 8'h0F));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 8'h0F));
    vecs.push_back(mk(0, 1, 2, 8'h33, 2, 1, 0, 1, 8'h33, 8'h0F));
    vecs.push_back(mk(0, 1, 2, 8'h44, 2, 1, 0, 1, 8'h44, 8'h0F));
    vecs.push_back(mk(0, 0, 0, 8'h00, 2, 2, 0, 0, 8'h44, 8'h44));
    vecs.push_back(mk(1, 0, 0, 8'h00, 2, 1, 1, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 0, 0, 8'h00, 2, 1, 1, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 0, 0, 8'h00, 2, 1, 1, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 1, 5, 8'hAA, 5, 5, 1, 0, 8'h00, 8'h00));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 8'h00, 5, 2, 1, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 0, 0, 8'h00, 5, 2, 0, 0, 8'h00, 8'h00));

    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].wr, vecs[k].ia, vecs[k].din, vecs[k].a1, vecs[k].a2);
      chk("tbl_busy", BUSY, vecs[k].e_busy);
      chk("tbl_wack", WACK, vecs[k].e_wack);
      chk("tbl_out1", OUT1, vecs[k].e_o1);
      chk("tbl_out2", OUT2, vecs[k].e_o2);
    end

    // Fill all registers, then reset with a restart mid-sweep.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 3'(i), 8'(8'h11 * (i + 1)), 3'(i), 0);
    step(0, 0, 0, 8'h00, 7, 4);
    chk("fill_r7", OUT1, 8'h88);
    chk("fill_r4", OUT2, 8'h55);
    step(1, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 1, 2);
    step(1, 0, 0, 8'h00, 1, 2);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 8'h00, 1, 2);
    step(1, 0, 0, 8'h00, 1, 2);
    bcnt = BUSY ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      if (!BUSY) break;
      step(0, 0, 0, 8'h00, 3, 6);
      if (BUSY) bcnt++;
    end
    chk("busy_len_after_rereset", 8'(bcnt), 8'd8);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 0, 8'h00, 3'(i), 3'(7 - i));
      chk("cleared_o1", OUT1, 8'h00);
      chk("cleared_o2", OUT2, 8'h00);
    end

    // Same-cycle read of the write target.
    @(negedge CLK);
    RESET = 0; WRITE = 1; INADDRESS = 3; IN = 8'h5C; OUT1ADDRESS = 3; OUT2ADDRESS = 0;
    #1;
`ifdef REG_FILE_BYPASS_EN
    chk("raw_pre_o1", OUT1, 8'h5C);
`else
    chk("raw_pre_o1", OUT1, 8'h00);
`endif
    chk("raw_pre_o2", OUT2, 8'h00);
    @(posedge CLK);
    model_edge(0, 1, 3, 8'h5C);
    #1;
    chk("raw_post_o1", OUT1, 8'h5C);
    chk("raw_post_wack", WACK, 8'd1);
    step(0, 0, 0, 8'h00, 3, 3);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1,
           3'($urandom_range(0, 7)), 8'($urandom),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
